// File: rtl/md_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_hazard_ctrl_pkg
//  Purpose  : Shared multiply/divide op encodings, HI/LO read select value
//             and op classification helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package md_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MFHI  = 4'd5,
    MDOP_MFLO  = 4'd6,
    MDOP_MTHI  = 4'd7,
    MDOP_MTLO  = 4'd8
  } mdop_e;

  // hilo_sel value that selects HI
  localparam logic MULDIV_HIGH = 1'b1;

  // Ops that occupy the arithmetic unit
  function automatic logic is_arith(input logic [3:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

  // Any multiply/divide-family op, including HI/LO moves
  function automatic logic is_md(input logic [3:0] op);
    return (op != MDOP_NONE);
  endfunction

  // Ops that take the long (divide) latency
  function automatic logic is_div(input logic [3:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage : md_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/md_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : md_hazard_ctrl_if
//  Purpose  : Pipeline-side bundle of the multiply/divide hazard controller.
//             master = pipeline / arithmetic unit, slave = controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface md_hazard_ctrl_if;
  import md_hazard_ctrl_pkg::*;

  // D/E stage op information and operands
  logic        d_valid;
  logic [3:0]  d_md_op;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        hilo_sel;

  // Controller responses
  logic        md_start;
  logic        md_busy;
  logic        stall_d;
  logic [31:0] hilo_rdata;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        err;

  modport master (
    output d_valid, d_md_op, e_valid, e_md_op, e_rs, arith_hi, arith_lo, hilo_sel,
    input  md_start, md_busy, stall_d, hilo_rdata, hi_q, lo_q, err
  );

  modport slave (
    input  d_valid, d_md_op, e_valid, e_md_op, e_rs, arith_hi, arith_lo, hilo_sel,
    output md_start, md_busy, stall_d, hilo_rdata, hi_q, lo_q, err
  );

endinterface : md_hazard_ctrl_if
`default_nettype wire

// File: rtl/md_hazard_ctrl_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : md_countdown
//  Purpose  : Loadable down-counter timing the arithmetic unit latency.
//             Load has priority over decrement; decrement stops at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module md_countdown #(
  parameter int unsigned CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: load on issue, otherwise count down towards zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : md_countdown
`default_nettype wire

// File: rtl/md_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : md_hazard_ctrl
//  Purpose  : Issue/hazard control for the multiply/divide unit. Fires start
//             pulses, times unit latency, holds the result until the latency
//             expires, owns HI/LO and raises the D-stage stall.
//  Revision : 1.0 - initial release
// ============================================================================
module md_hazard_ctrl
  import md_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  // 2**CNT_W must exceed DIV_LAT so the loaded value fits
  parameter int unsigned CNT_W   = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  md_hazard_ctrl_if.slave bus
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_err;

  logic             w_idle;
  logic             w_busy;
  logic             w_md_start;
  logic             w_commit;
  logic             w_violation;
  logic             w_cnt_zero;
  logic             w_e_md;
  logic [CNT_W-1:0] w_load_val;

  assign w_e_md     = bus.e_valid & is_md(bus.e_md_op);
  assign w_load_val = is_div(bus.e_md_op) ? c_DIV_LOAD : c_MUL_LOAD;

  md_countdown #(
    .CNT_W (CNT_W)
  ) u_countdown (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_md_start),
    .i_load_val (w_load_val),
    .i_dec      (w_busy),
    .o_zero     (w_cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave IDLE on issue, return once the countdown hits zero
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_md_start) w_state_nxt = c_ST_BUSY;
      c_ST_BUSY: if (w_cnt_zero) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs: issue pulse, occupancy, commit strobe and protocol check
  always_comb begin
    w_idle      = (r_state == c_ST_IDLE);
    w_busy      = (r_state == c_ST_BUSY);
    w_md_start  = w_idle & bus.e_valid & is_arith(bus.e_md_op);
    w_commit    = w_busy & w_cnt_zero;
    w_violation = w_busy & w_e_md;
  end

  // Result is captured at issue; the arithmetic inputs may change afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (w_md_start) begin
      r_pend_hi <= bus.arith_hi;
      r_pend_lo <= bus.arith_lo;
    end
  end

  // Architectural HI/LO: latency-expired commit or direct move while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end else if (w_idle && bus.e_valid) begin
      if (bus.e_md_op == MDOP_MTHI) r_hi <= bus.e_rs;
      if (bus.e_md_op == MDOP_MTLO) r_lo <= bus.e_rs;
    end
  end

  // Sticky flag for any md op reaching E while the unit is occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_violation) begin
      r_err <= 1'b1;
    end
  end

  assign bus.md_start   = w_md_start;
  assign bus.md_busy    = w_busy;
  assign bus.stall_d    = bus.d_valid & is_md(bus.d_md_op) & (w_md_start | w_busy);
  assign bus.hilo_rdata = (bus.hilo_sel == MULDIV_HIGH) ? r_hi : r_lo;
  assign bus.hi_q       = r_hi;
  assign bus.lo_q       = r_lo;
  assign bus.err        = r_err;

endmodule : md_hazard_ctrl
`default_nettype wire

// File: tb/tb_md_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_hazard_ctrl
//  Purpose  : Directed self-checking bench for md_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_hazard_ctrl;
  import md_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  md_hazard_ctrl_if bus ();

  md_hazard_ctrl #(
    .MUL_LAT (5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the start of the next cycle, just after the active edge
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs
  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    bus.d_valid  = 1'b0;
    bus.d_md_op  = MDOP_NONE;
    bus.e_valid  = 1'b0;
    bus.e_md_op  = MDOP_NONE;
    bus.e_rs     = 32'h0;
    bus.arith_hi = 32'hFFFF_FFFF;
    bus.arith_lo = 32'hFFFF_FFFF;
    bus.hilo_sel = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] hi, input logic [31:0] lo);
    bus.e_valid  = 1'b1;
    bus.e_md_op  = op;
    bus.arith_hi = hi;
    bus.arith_lo = lo;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "simulation timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    settle();
    check("rst_start", 32'(bus.md_start), 32'h0);
    check("rst_busy",  32'(bus.md_busy),  32'h0);
    check("rst_stall", 32'(bus.stall_d),  32'h0);
    check("rst_hi",    bus.hi_q,          32'h0);
    check("rst_lo",    bus.lo_q,          32'h0);
    check("rst_err",   32'(bus.err),      32'h0);

    // 1. MULT: start only in cycle 0, busy 1..5, result from cycle 6
    next_cycle();
    issue(MDOP_MULT, 32'h1, 32'h2);
    settle();
    check("t1_start_c0", 32'(bus.md_start), 32'h1);
    check("t1_busy_c0",  32'(bus.md_busy),  32'h0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      idle_inputs();
      settle();
      check($sformatf("t1_busy_c%0d", c),  32'(bus.md_busy),  32'h1);
      check($sformatf("t1_start_c%0d", c), 32'(bus.md_start), 32'h0);
      check($sformatf("t1_hi_c%0d", c),    bus.hi_q,          32'h0);
    end
    next_cycle();
    settle();
    check("t1_busy_c6", 32'(bus.md_busy), 32'h0);
    check("t1_hi_c6",   bus.hi_q,         32'h1);
    check("t1_lo_c6",   bus.lo_q,         32'h2);

    // 2. DIV with MFLO held in D: stall 0..10, released in 11
    next_cycle();
    issue(MDOP_DIV, 32'h0000_AAAA, 32'h0000_5555);
    bus.d_valid = 1'b1;
    bus.d_md_op = MDOP_MFLO;
    settle();
    check("t2_stall_c0", 32'(bus.stall_d), 32'h1);
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      bus.e_valid  = 1'b0;
      bus.e_md_op  = MDOP_NONE;
      bus.arith_hi = 32'hFFFF_FFFF;
      bus.arith_lo = 32'hFFFF_FFFF;
      settle();
      check($sformatf("t2_stall_c%0d", c), 32'(bus.stall_d), 32'h1);
    end
    next_cycle();
    settle();
    check("t2_stall_c11", 32'(bus.stall_d), 32'h0);
    check("t2_lo_c11",    bus.lo_q,         32'h0000_5555);
    next_cycle();
    bus.d_valid  = 1'b0;
    bus.d_md_op  = MDOP_NONE;
    bus.e_valid  = 1'b1;
    bus.e_md_op  = MDOP_MFLO;
    bus.hilo_sel = 1'b0;
    settle();
    check("t2_rdata_lo", bus.hilo_rdata,     32'h0000_5555);
    check("t2_mflo_start", 32'(bus.md_start), 32'h0);
    bus.hilo_sel = MULDIV_HIGH;
    settle();
    check("t2_rdata_hi", bus.hilo_rdata, 32'h0000_AAAA);

    // 3. MTHI/MTLO while idle, MFHI in D behind MTHI does not stall
    next_cycle();
    idle_inputs();
    bus.e_valid = 1'b1;
    bus.e_md_op = MDOP_MTHI;
    bus.e_rs    = 32'h1234;
    bus.d_valid = 1'b1;
    bus.d_md_op = MDOP_MFHI;
    settle();
    check("t3_stall",  32'(bus.stall_d),  32'h0);
    check("t3_start",  32'(bus.md_start), 32'h0);
    next_cycle();
    bus.d_valid  = 1'b0;
    bus.d_md_op  = MDOP_NONE;
    bus.e_md_op  = MDOP_MTLO;
    bus.e_rs     = 32'h5678;
    bus.hilo_sel = MULDIV_HIGH;
    settle();
    check("t3_hi",    bus.hi_q,         32'h1234);
    check("t3_busy",  32'(bus.md_busy), 32'h0);
    check("t3_rdata", bus.hilo_rdata,   32'h1234);
    next_cycle();
    idle_inputs();
    settle();
    check("t3_lo",    bus.lo_q,         32'h5678);
    check("t3_hi2",   bus.hi_q,         32'h1234);
    check("t3_busy2", 32'(bus.md_busy), 32'h0);

    // 4. Reset in cycle 3 of a DIV discards it
    next_cycle();
    issue(MDOP_DIV, 32'hDEAD, 32'hBEEF);
    settle();
    check("t4_start", 32'(bus.md_start), 32'h1);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    settle();
    check("t4_busy_c3", 32'(bus.md_busy), 32'h1);
    next_cycle();
    reset = 1'b0;
    settle();
    check("t4_busy_c4", 32'(bus.md_busy), 32'h0);
    check("t4_hi_c4",   bus.hi_q,         32'h0);
    check("t4_lo_c4",   bus.lo_q,         32'h0);
    for (int c = 5; c <= 13; c++) begin
      next_cycle();
      settle();
      check($sformatf("t4_hi_c%0d", c),   bus.hi_q,         32'h0);
      check($sformatf("t4_lo_c%0d", c),   bus.lo_q,         32'h0);
      check($sformatf("t4_busy_c%0d", c), 32'(bus.md_busy), 32'h0);
    end

    // 5. MULT forced into E while busy: ignored, err sticky until reset
    next_cycle();
    issue(MDOP_MULT, 32'h7, 32'h8);
    settle();
    next_cycle();
    issue(MDOP_MULT, 32'h9, 32'h9);
    settle();
    check("t5_start_c1", 32'(bus.md_start), 32'h0);
    check("t5_err_c1",   32'(bus.err),      32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("t5_err_c2",  32'(bus.err),     32'h1);
    check("t5_busy_c2", 32'(bus.md_busy), 32'h1);
    for (int c = 3; c <= 5; c++) begin
      next_cycle();
      settle();
      check($sformatf("t5_busy_c%0d", c), 32'(bus.md_busy), 32'h1);
    end
    next_cycle();
    settle();
    check("t5_busy_c6", 32'(bus.md_busy), 32'h0);
    check("t5_hi_c6",   bus.hi_q,         32'h7);
    check("t5_lo_c6",   bus.lo_q,         32'h8);
    check("t5_err_c6",  32'(bus.err),     32'h1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    settle();
    check("t5_err_rst", 32'(bus.err), 32'h0);

    // 6. MULT then MULTU waiting in D: back-to-back issue
    next_cycle();
    issue(MDOP_MULT, 32'h11, 32'h22);
    bus.d_valid = 1'b1;
    bus.d_md_op = MDOP_MULTU;
    settle();
    check("t6_stall_c0", 32'(bus.stall_d),  32'h1);
    check("t6_start_c0", 32'(bus.md_start), 32'h1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      bus.e_valid  = 1'b0;
      bus.e_md_op  = MDOP_NONE;
      bus.arith_hi = 32'hFFFF_FFFF;
      bus.arith_lo = 32'hFFFF_FFFF;
      settle();
      check($sformatf("t6_stall_c%0d", c), 32'(bus.stall_d),  32'h1);
      check($sformatf("t6_start_c%0d", c), 32'(bus.md_start), 32'h0);
    end
    next_cycle();
    bus.d_valid = 1'b0;
    bus.d_md_op = MDOP_NONE;
    issue(MDOP_MULTU, 32'h33, 32'h44);
    settle();
    check("t6_stall_c6", 32'(bus.stall_d),  32'h0);
    check("t6_start_c6", 32'(bus.md_start), 32'h1);
    check("t6_hi_c6",    bus.hi_q,          32'h11);
    check("t6_lo_c6",    bus.lo_q,          32'h22);
    for (int c = 7; c <= 11; c++) begin
      next_cycle();
      idle_inputs();
      settle();
      check($sformatf("t6_busy_c%0d", c), 32'(bus.md_busy), 32'h1);
      check($sformatf("t6_hi_c%0d", c),   bus.hi_q,         32'h11);
    end
    next_cycle();
    settle();
    check("t6_busy_c12", 32'(bus.md_busy), 32'h0);
    check("t6_hi_c12",   bus.hi_q,         32'h33);
    check("t6_lo_c12",   bus.lo_q,         32'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_md_hazard_ctrl
`default_nettype wire
